wb_cache_memory_unit: RTL and testbench

Parametrised successor of the data memory unit: a direct-mapped, write-back, write-allocate data cache with per-line valid/dirty state. A miss FSM talks to an external multi-cycle backing memory over a req/ack line interface. It raises `stall` to the core while a miss is serviced. RISC-V byte/half/word load/store formatting is done inside the block and selected by DATAMEMControl.

---
 rtl/wb_cache_memory_unit.sv | 205 ++++++++++++++++++++
 tb/tb_wb_cache_memory_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cache_memory_unit.sv
// Direct-mapped, write-back, write-allocate data cache with RISC-V load/store
// formatting and a req/ack line interface to a multi-cycle backing memory.
module wb_cache_memory_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned CACHE_SIZE    = 3,
  parameter int unsigned BLOCK_SIZE    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ADDRESS_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]               write_data,
  input  logic [2:0]                          DATAMEMControl,
  input  logic                                write_enable,
  input  logic                                read_en,
  output logic [DATA_WIDTH-1:0]               read_data,
  output logic                                stall,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDRESS_WIDTH-1:0]            mem_addr,
  output logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0] mem_wdata,
  input  logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0] mem_rdata,
  input  logic                                mem_ack
);

  localparam int unsigned LINE_W  = DATA_WIDTH << BLOCK_SIZE;
  localparam int unsigned SETS    = 1 << CACHE_SIZE;
  localparam int unsigned OFF_W   = BLOCK_SIZE + 2;
  localparam int unsigned TAG_W   = ADDRESS_WIDTH - CACHE_SIZE - OFF_W;
  localparam int unsigned DW_LOG  = $clog2(DATA_WIDTH);
  localparam int unsigned LB_W    = $clog2(LINE_W);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]               state, state_nxt;
  logic                     req_nxt, we_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_nxt;
  logic [LINE_W-1:0]        wdata_nxt;

  logic [SETS-1:0]   valid, dirty;
  logic [TAG_W-1:0]  tag_store  [SETS];
  logic [LINE_W-1:0] data_store [SETS];

  logic [1:0]            offset;
  logic [BLOCK_SIZE-1:0] word_sel;
  logic [CACHE_SIZE-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic [LB_W-1:0]       word_base;

  logic                  access, hit, fill, store_hit;
  logic [1:0]            size;
  logic                  unsigned_ld;
  logic [LINE_W-1:0]     cur_line, store_line;
  logic [DATA_WIDTH-1:0] cur_word, store_word, load_val;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;

  assign offset    = address[1:0];
  assign word_sel  = address[OFF_W-1:2];
  assign index     = address[OFF_W +: CACHE_SIZE];
  assign tag       = address[ADDRESS_WIDTH-1 -: TAG_W];
  assign word_base = {word_sel, {DW_LOG{1'b0}}};

  assign cur_line = data_store[index];
  assign cur_word = cur_line[word_base +: DATA_WIDTH];
  assign byte_val = cur_word[{offset, 3'b000} +: 8];
  assign half_val = cur_word[{offset[1], 4'b0000} +: 16];

  assign access    = read_en | write_enable;
  assign hit       = valid[index] && (tag_store[index] == tag) && (state == IDLE);
  assign fill      = (state == REFILL) && mem_ack;
  assign store_hit = write_enable && hit;

  // Reset forces the core-facing outputs low even while a request is held.
  assign stall = rst_n & access & ~hit;

  // Access size and signedness from funct3; unknown codes behave as word.
  always_comb begin
    size        = SZ_W;
    unsigned_ld = 1'b0;
    case (DATAMEMControl)
      3'b000:  size = SZ_B;
      3'b001:  size = SZ_H;
      3'b100: begin
        size        = SZ_B;
        unsigned_ld = 1'b1;
      end
      3'b101: begin
        size        = SZ_H;
        unsigned_ld = 1'b1;
      end
      default: size = SZ_W;
    endcase
  end

  // Load formatting: byte/half picked by offset, then sign or zero extended.
  always_comb begin
    load_val = cur_word;
    case (size)
      SZ_B:    load_val = {{(DATA_WIDTH-8){byte_val[7] & ~unsigned_ld}}, byte_val};
      SZ_H:    load_val = {{(DATA_WIDTH-16){half_val[15] & ~unsigned_ld}}, half_val};
      default: load_val = cur_word;
    endcase
  end

  assign read_data = (rst_n && read_en && !write_enable && hit) ? load_val : '0;

  // Store merge: naturally aligned lane update, rest of the line preserved.
  always_comb begin
    store_word = cur_word;
    case (size)
      SZ_B:    store_word[{offset, 3'b000} +: 8]     = write_data[7:0];
      SZ_H:    store_word[{offset[1], 4'b0000} +: 16] = write_data[15:0];
      default: store_word = write_data;
    endcase
    store_line = cur_line;
    store_line[word_base +: DATA_WIDTH] = store_word;
  end

  // Miss sequencing; memory-side outputs hold their value unless changed here.
  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (access && !hit) begin
          req_nxt = 1'b1;
          if (valid[index] && dirty[index]) begin
            state_nxt = WRITEBACK;
            we_nxt    = 1'b1;
            addr_nxt  = {tag_store[index], index, {OFF_W{1'b0}}};
            wdata_nxt = data_store[index];
          end else begin
            state_nxt = REFILL;
            we_nxt    = 1'b0;
            addr_nxt  = {tag, index, {OFF_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          state_nxt = REFILL;
          we_nxt    = 1'b0;
          addr_nxt  = {tag, index, {OFF_W{1'b0}}};
        end
      end
      REFILL: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
      end
    endcase
  end

  // Control state and line status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid     <= '0;
      dirty     <= '0;
    end else begin
      state     <= state_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      if (fill) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end else if (store_hit) begin
        dirty[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_store[index] <= mem_rdata;
      tag_store[index]  <= tag;
    end else if (store_hit) begin
      data_store[index] <= store_line;
    end
  end

endmodule

// File: tb/tb_wb_cache_memory_unit.sv
// Bench for wb_cache_memory_unit: byte-level golden memory plus line residency
// model, a reactive backing memory, directed literal checks and random traffic.
module tb_wb_cache_memory_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  address;
  logic [31:0]  write_data;
  logic [2:0]   funct3;
  logic         write_enable;
  logic         read_en;
  logic [31:0]  read_data;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  wb_cache_memory_unit #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .CACHE_SIZE(3), .BLOCK_SIZE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
    .DATAMEMControl(funct3), .write_enable(write_enable), .read_en(read_en),
    .read_data(read_data), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  int errors = 0;
  int checks = 0;

  txn_t exp_q[$];
  txn_t log_q[$];
  logic [127:0] backing [int unsigned];
  logic [7:0]   golden  [int unsigned];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  bit           pending = 1'b0;
  int           ack_delay = 0;
  bit           spurious = 1'b0;
  logic [2:0]   scodes [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] la);
    logic [127:0] l;
    logic [31:0]  w;
    l = '0;
    for (int k = 0; k < 4; k++) begin
      w = la * 32'h9E37_79B1 + 32'(k) * 32'h0001_0DB5 + 32'h0000_3039;
      l = l | (128'(w) << (32 * k));
    end
    return l;
  endfunction

  function automatic logic [127:0] backing_line(input logic [31:0] la);
    if (backing.exists(la)) return backing[la];
    return init_line(la);
  endfunction

  // Architectural byte: latest store if any, otherwise backing memory.
  function automatic logic [7:0] gbyte(input logic [31:0] a);
    logic [127:0] sh;
    if (golden.exists(a)) return golden[a];
    sh = backing_line({a[31:4], 4'b0000}) >> {a[3:0], 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic [127:0] golden_line(input logic [31:0] la);
    logic [127:0] l;
    l = '0;
    for (int b = 0; b < 16; b++) l = l | (128'(gbyte(la + 32'(b))) << (8 * b));
    return l;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    logic [7:0]  b0;
    logic [15:0] h;
    logic [31:0] hb, wb;
    b0 = gbyte(a);
    hb = a & 32'hFFFF_FFFE;
    wb = a & 32'hFFFF_FFFC;
    h  = {gbyte(hb + 32'd1), gbyte(hb)};
    case (f)
      3'b000:  return 32'($signed(b0));
      3'b100:  return 32'(b0);
      3'b001:  return 32'($signed(h));
      3'b101:  return 32'(h);
      default: return {gbyte(wb + 32'd3), gbyte(wb + 32'd2), gbyte(wb + 32'd1), gbyte(wb)};
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    logic [31:0] hb, wb;
    hb = a & 32'hFFFF_FFFE;
    wb = a & 32'hFFFF_FFFC;
    case (f)
      3'b000, 3'b100: golden[a] = d[7:0];
      3'b001, 3'b101: begin
        golden[hb]         = d[7:0];
        golden[hb + 32'd1] = d[15:8];
      end
      default: begin
        golden[wb]         = d[7:0];
        golden[wb + 32'd1] = d[15:8];
        golden[wb + 32'd2] = d[23:16];
        golden[wb + 32'd3] = d[31:24];
      end
    endcase
  endtask

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin : compare
    logic [2:0]  idx;
    logic [24:0] tg;
    logic [31:0] vla;
    bit          acc, hit;
    idx = address[6:4];
    tg  = address[31:7];
    acc = read_en | write_enable;
    if (!rst_n) begin
      chk1("reset_stall", stall, 1'b0);
      chk32("reset_read_data", read_data, 32'h0);
      chk1("reset_mem_req", mem_req, 1'b0);
      for (int i = 0; i < 8; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
      end
      golden.delete();
      exp_q.delete();
      pending = 1'b0;
    end else begin
      hit = m_valid[idx] && (m_tag[idx] == tg);
      chk1("stall", stall, acc && !hit);
      chk32("read_data", read_data,
            (read_en && !write_enable && hit) ? model_load(address, funct3) : 32'h0);
      chk1("mem_req", mem_req, pending);
      if (acc && !hit && !pending) begin
        vla = {m_tag[idx], idx, 4'b0000};
        if (m_valid[idx] && m_dirty[idx]) exp_q.push_back('{1'b1, vla, golden_line(vla)});
        exp_q.push_back('{1'b0, {tg, idx, 4'b0000}, 128'h0});
        pending = 1'b1;
      end
      if (mem_req && mem_ack && !mem_we) begin
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = tg;
        pending      = 1'b0;
      end else if (hit && write_enable) begin
        model_store(address, funct3, write_data);
        m_dirty[idx] = 1'b1;
      end
    end
  end

  // Backing memory: checks each line transaction, holds stability, acks after a delay.
  initial begin : responder
    bit   active;
    int   left;
    txn_t cur, e;
    active    = 1'b0;
    left      = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          cur    = '{mem_we, mem_addr, mem_wdata};
          left   = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
          log_q.push_back(cur);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_txn_unexpected: got we=%b addr=%h expected none", mem_we, mem_addr);
          end else begin
            e = exp_q.pop_front();
            chk1("mem_we", mem_we, e.we);
            chk32("mem_addr", mem_addr, e.addr);
            if (e.we) chk128("mem_wdata", mem_wdata, e.wdata);
          end
        end else begin
          chk32("mem_addr_hold", mem_addr, cur.addr);
          chk1("mem_we_hold", mem_we, cur.we);
        end
        if (left == 0) begin
          mem_ack = 1'b1;
          active  = 1'b0;
          if (cur.we) backing[cur.addr] = mem_wdata;
          else        mem_rdata = backing_line(cur.addr);
        end else begin
          left--;
        end
      end else if (spurious && ($urandom_range(0, 3) == 0)) begin
        mem_ack   = 1'b1;
        mem_rdata = {4{$urandom()}};
      end
    end
  end

  task automatic op(input logic [31:0] a, input logic [2:0] f, input bit st, input bit ld,
                    input logic [31:0] wd, output logic [31:0] rd, output int waits);
    @(posedge clk);
    #1;
    address      = a;
    funct3       = f;
    write_enable = st;
    read_en      = ld;
    write_data   = wd;
    waits        = 0;
    rd           = '0;
    forever begin
      @(negedge clk);
      if (!stall) begin
        rd = read_data;
        break;
      end
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL op_timeout: addr %h still stalled after %0d cycles, required release", a, waits);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_en      = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    int          waits;
    int          n;
    bit          st, ld;
    logic [2:0]  f;

    rst_n        = 1'b1;
    address      = '0;
    write_data   = '0;
    funct3       = 3'b010;
    write_enable = 1'b0;
    read_en      = 1'b0;
    backing[32'h100] = {32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF};
    backing[32'h180] = {32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA, 32'h1234_5678};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk128("rst_mem_wdata", mem_wdata, 128'h0);
    chk1("rst_stall", stall, 1'b0);
    chk32("rst_read_data", read_data, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold miss, then zero-wait hits on the filled line.
    ack_delay = 0;
    log_q.delete();
    op(32'h100, 3'b010, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("lw_miss_data", rd, 32'hDEAD_BEEF);
    chk32("lw_miss_waits", 32'(waits), 32'd2);
    chk32("lw_miss_txns", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk1("lw_miss_we", log_q[0].we, 1'b0);
      chk32("lw_miss_addr", log_q[0].addr, 32'h100);
    end
    op(32'h103, 3'b000, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("lb_103", rd, 32'hFFFF_FFDE);
    chk32("lb_103_waits", 32'(waits), 32'd0);
    op(32'h103, 3'b100, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("lbu_103", rd, 32'h0000_00DE);
    op(32'h102, 3'b001, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("lh_102", rd, 32'hFFFF_DEAD);
    op(32'h101, 3'b000, 1'b1, 1'b0, 32'h0000_0077, rd, waits);
    chk32("sb_101_waits", 32'(waits), 32'd0);
    op(32'h100, 3'b010, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("lw_after_sb", rd, 32'hDEAD_77EF);
    chk32("no_extra_txn", 32'(log_q.size()), 32'd1);

    // Conflict on a dirty line: writeback then refill, 5-cycle ack delay each.
    log_q.delete();
    ack_delay = 5;
    op(32'h180, 3'b010, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("conflict_data", rd, 32'h1234_5678);
    chk32("conflict_waits", 32'(waits), 32'd13);
    chk32("conflict_txns", 32'(log_q.size()), 32'd2);
    if (log_q.size() > 1) begin
      chk1("wb_we", log_q[0].we, 1'b1);
      chk32("wb_addr", log_q[0].addr, 32'h100);
      chk32("wb_word0", log_q[0].wdata[31:0], 32'hDEAD_77EF);
      chk1("rf_we", log_q[1].we, 1'b0);
      chk32("rf_addr", log_q[1].addr, 32'h180);
    end

    // Clean victim: refill only, written-back data returns.
    log_q.delete();
    ack_delay = 0;
    op(32'h100, 3'b010, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("clean_victim_data", rd, 32'hDEAD_77EF);
    chk32("clean_victim_waits", 32'(waits), 32'd2);
    chk32("clean_victim_txns", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk1("clean_victim_we", log_q[0].we, 1'b0);

    // Spurious acks while idle must not disturb the cache.
    spurious = 1'b1;
    idle(12);
    spurious = 1'b0;
    op(32'h104, 3'b010, 1'b0, 1'b1, 32'h0, rd, waits);
    chk32("after_spurious_data", rd, 32'h3333_4444);
    chk32("after_spurious_waits", 32'(waits), 32'd0);

    // Random traffic over four tags per set.
    ack_delay = -1;
    spurious  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 2) == 0);
      ld = ($urandom_range(0, 3) != 0);
      f  = st ? scodes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      op(32'($urandom_range(0, 511)), f, st, ld, $urandom(), rd, waits);
    end
    spurious  = 1'b0;
    ack_delay = 0;

    // Reset in the middle of a refill.
    op(32'h100, 3'b010, 1'b0, 1'b1, 32'h0, rd, waits);
    ack_delay = 5;
    @(posedge clk);
    #1;
    address      = 32'h180;
    funct3       = 3'b010;
    read_en      = 1'b1;
    write_enable = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL refill_timeout: no refill request seen, required one");
    end
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_mem_req", mem_req, 1'b0);
    chk1("async_rst_stall", stall, 1'b0);
    chk32("async_rst_read_data", read_data, 32'h0);
    @(posedge clk);
    #1 read_en = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ack_delay = 0;
    op(32'h100, 3'b010, 1'b0, 1'b1, 32'h0, rd, waits);
    chk1("post_reset_miss", waits > 0, 1'b1);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
